// File: rtl/rn_dispatch_buf.sv
// rn_dispatch_buf: circular buffer between the rename stage and dispatch.
// It holds up to DEPTH renamed instructions and hands them to the issue/ROB
// side in program order. There is no bypass, so an instruction pushed into an
// empty buffer becomes visible one cycle later.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   EN            global enable; low holds all state and ignores flush
//   flush         clears the buffer (mispredict / exception)
//   in_valid      RN stage offers an instruction
//   in_PC/in_inst/in_FUType/in_ctrl   offered payload
//   stall         hold request to the ID/RN register (offer while full)
//   out_valid     head entry available
//   out_ready     consumer takes the head this cycle
//   out_PC/out_inst/out_FUType/out_ctrl   head payload (don't-care when !out_valid)
//   count         occupied entries, 0..DEPTH
module rn_dispatch_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = 88
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     EN,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_PC,
    input  logic [31:0]              in_inst,
    input  logic [2:0]               in_FUType,
    input  logic [20:0]              in_ctrl,
    output logic                     stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_PC,
    output logic [31:0]              out_inst,
    output logic [2:0]               out_FUType,
    output logic [20:0]              out_ctrl,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Entry layout, LSB first: ctrl[20:0], FUType[23:21], inst[55:24], PC[87:56]
    localparam int unsigned CTRL_LSB = 0;
    localparam int unsigned FU_LSB   = 21;
    localparam int unsigned INST_LSB = 24;
    localparam int unsigned PC_LSB   = 56;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_data;
    logic [PW-1:0] rd_data;

    // Status and handshakes, derived only from registered occupancy
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        push    = EN & ~flush & in_valid & ~full;
        pop     = EN & ~flush & ~empty & out_ready;
        wr_data = PW'({in_PC, in_inst, in_FUType, in_ctrl});
    end

    // Occupancy update; simultaneous push and pop cancel
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Pointers and occupancy; flush wins over push/pop but only while enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (EN) begin
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count_q <= count_nxt;
            end
        end
    end

    // Payload storage needs no reset; stale data is masked by out_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head presentation and upstream back-pressure
    always_comb begin
        rd_data    = mem[rd_ptr];
        out_valid  = ~empty;
        stall      = in_valid & full;
        count      = count_q;
        out_PC     = rd_data[PC_LSB   +: 32];
        out_inst   = rd_data[INST_LSB +: 32];
        out_FUType = rd_data[FU_LSB   +: 3];
        out_ctrl   = rd_data[CTRL_LSB +: 21];
    end

endmodule
